tlb_op_ctrl: RTL and testbench
==============================

# tlb_op_ctrl

Multi-cycle sequencer for the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR. It sits between the CP0/MEM stage and the TLB array. It borrows the TLB's shared search port 1 from the EXE-stage address translation for probes, and drives the TLB read and write ports. It also keeps the CP0 Random counter and signals CP0 writeback and the pipeline refetch on completion.

## Interface
- TLBNUM, 16, number of TLB entries
- IDX_W, 4, index width, equal to log2(TLBNUM)
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high
- op_valid  in  1  TLB instruction request from the MEM stage
- op_type  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_ready  out  1  controller accepts a request this cycle
- flush  in  1  pipeline flush (exception or ERET)
- cp0_entryhi_vpn2  in  19  EntryHi VPN2 used for the probe
- cp0_entryhi_asid  in  8  EntryHi ASID used for the probe
- cp0_index  in  IDX_W  CP0 Index register
- cp0_wired  in  IDX_W  CP0 Wired register
- cp0_wired_we  in  1  CP0 Wired is being written this cycle
- exe_lookup_req  in  1  EXE stage needs search port 1 this cycle
- exe_stall  out  1  EXE must hold because the port is owned here
- s1_sel  out  1  1 means the search-port-1 mux selects the controller's vpn2/asid
- s1_vpn2  out  19  probe VPN2
- s1_asid  out  8  probe ASID
- s1_found  in  1  search hit
- s1_index  in  IDX_W  index of the hitting entry
- r_index  out  IDX_W  TLB read-port index
- we  out  1  TLB write enable
- w_index  out  IDX_W  TLB write index
- cp0_random  out  IDX_W  current Random value
- op_done  out  1  one-cycle completion pulse
- cp0_index_we  out  1  load the probe result into CP0 Index
- probe_miss  out  1  Index.P value
- probe_index  out  IDX_W  Index.Index value
- cp0_tlbr_we  out  1  load EntryHi/EntryLo0/EntryLo1/PageMask from the TLB read port
- refetch  out  1  refetch from the instruction after the TLB write

## Operation
- FSM states:
  - IDLE: op_ready=1. If op_valid and not flush, go to PROBE (TLBP), READ (TLBR) or WRITE (TLBWI/TLBWR). Otherwise stay.
  - PROBE:
    - Outputs: s1_sel=1, s1_vpn2=cp0_entryhi_vpn2, s1_asid=cp0_entryhi_asid. exe_stall=exe_lookup_req.
    - Register probe_miss=!s1_found and probe_index=(s1_found ? s1_index : 0).
    - Go to DONE.
  - READ: r_index=cp0_index. Go to DONE.
  - WRITE:
    - we=1. w_index=cp0_index for TLBWI; w_index=the Random value captured at acceptance for TLBWR.
    - Go to DONE.
  - DONE:
    - op_done=1.
    - TLBP: cp0_index_we=1. TLBR: cp0_tlbr_we=1, and r_index is held at the captured cp0_index. TLBWI/TLBWR: refetch=1.
    - Go to IDLE.
- Latched at acceptance: op_type and cp0_index. Later changes to the CP0 inputs are ignored.
- The EXE stage owns search port 1 in every state except PROBE. s1_sel=0 outside PROBE.
- Random counter:
  - Decrements by 1 every cycle.
  - When it equals cp0_wired, the next value is TLBNUM-1 instead.
  - If cp0_wired ≥ TLBNUM-1, it holds at TLBNUM-1.
  - cp0_wired_we forces TLBNUM-1 on the next edge; this has priority over decrementing.
  - The value is never below cp0_wired after one cycle.
- flush:
  - In PROBE or READ: go to IDLE, no op_done, no CP0 strobes.
  - In WRITE or DONE: ignored. The write is committed and DONE completes normally.
  - In IDLE: blocks acceptance that cycle.
- Only one op is in flight at a time. op_ready=0 from acceptance until the return to IDLE.

## Timing
- Reset values: state IDLE, op_ready=1, random=TLBNUM-1. All other outputs and registers 0: s1_sel, exe_stall, we, op_done, cp0_index_we, cp0_tlbr_we, refetch, probe_miss, probe_index, w_index, r_index, s1_vpn2, s1_asid.
- Reset mid-operation aborts immediately. No write is issued after reset is asserted.
- Op accepted in cycle T:
  - Work cycle (PROBE/READ/WRITE) is T+1. op_done is T+2.
  - Next acceptance is possible at T+3.
- Probe search is combinational inside the TLB. Its result is sampled on the edge that ends T+1 and presented in T+2.
- TLB write takes effect at the edge that ends T+1. A probe accepted afterwards sees the new entry.
- exe_stall is combinational: state==PROBE && exe_lookup_req. It is asserted for exactly one cycle per TLBP.
- All outputs except exe_stall and op_ready are registered or decoded from state and registers only. No input-to-output path exists except s1_found/s1_index into the registers.

## Test plan
- Reset with cp0_wired=0 → random=15, then 14, 13, … 0, 15 on consecutive cycles; op_ready=1; all strobes 0.
- TLBP, EntryHi vpn2=0x12345, ASID=0x07, matching entry 9 preloaded → s1_sel=1 in T+1; in T+2: op_done=1, cp0_index_we=1, probe_miss=0, probe_index=9. Repeat with no matching entry → probe_miss=1, probe_index=0.
- TLBP with exe_lookup_req=1 held throughout → exe_stall=1 only in T+1. The EXE lookup in T+2 returns the EXE address translation.
- TLBWR with cp0_wired=12 → w_index is always within 12..15 over 50 writes. Assert cp0_wired_we mid-run → random=15 the next cycle.
- TLBWI with cp0_index=3, then TLBR with cp0_index=3 → we=1 in the WRITE cycle with w_index=3, refetch pulse; TLBR DONE has r_index=3, cp0_tlbr_we=1.
- flush during PROBE → no op_done, no cp0_index_we, op_ready=1 the next cycle. flush during WRITE → we=1 still, op_done and refetch in the following cycle.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR.
// Ports: op_valid/op_type/op_ready request; flush; CP0 EntryHi/Index/
//   Wired inputs; search port 1 (s1_*) shared with EXE (exe_lookup_req,
//   exe_stall); TLB read (r_index) and write (we, w_index); CP0 Random
//   (cp0_random); completion strobes (op_done, cp0_index_we,
//   probe_miss, probe_index, cp0_tlbr_we, refetch).
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op_type,
    output logic             op_ready,
    input  logic             flush,
    input  logic [18:0]      cp0_entryhi_vpn2,
    input  logic [7:0]       cp0_entryhi_asid,
    input  logic [IDX_W-1:0] cp0_index,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             cp0_wired_we,
    input  logic             exe_lookup_req,
    output logic             exe_stall,
    output logic             s1_sel,
    output logic [18:0]      s1_vpn2,
    output logic [7:0]       s1_asid,
    input  logic             s1_found,
    input  logic [IDX_W-1:0] s1_index,
    output logic [IDX_W-1:0] r_index,
    output logic             we,
    output logic [IDX_W-1:0] w_index,
    output logic [IDX_W-1:0] cp0_random,
    output logic             op_done,
    output logic             cp0_index_we,
    output logic             probe_miss,
    output logic [IDX_W-1:0] probe_index,
    output logic             cp0_tlbr_we,
    output logic             refetch
);

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PROBE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W-1:0] RND_MAX = IDX_W'(TLBNUM - 1);
    localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [1:0]       op_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] rnd_q;
    logic [IDX_W-1:0] rnd_d;
    logic [IDX_W-1:0] rnd_cap_q;
    logic [IDX_W-1:0] pidx_q;
    logic             pmiss_q;
    logic [18:0]      vpn2_q;
    logic [7:0]       asid_q;
    logic             accept;
    logic             in_probe;
    logic             in_done;

    assign accept   = (state_q == S_IDLE) && op_valid && !flush;
    assign in_probe = (state_q == S_PROBE);
    assign in_done  = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        op_type == OP_TLBP: state_d = S_PROBE;
                        op_type == OP_TLBR: state_d = S_READ;
                        default:            state_d = S_WRITE;
                    endcase
                end
            end
            // A flush kills a probe/read before any CP0 update; a write
            // is already committed to the array, so it always completes.
            S_PROBE: state_d = flush ? S_IDLE : S_DONE;
            S_READ:  state_d = flush ? S_IDLE : S_DONE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reloading whenever Random is at or below Wired keeps it inside
    // [Wired, TLBNUM-1], and also pins it when Wired >= TLBNUM-1.
    always_comb begin
        rnd_d = rnd_q - ONE;
        if (cp0_wired_we || (rnd_q <= cp0_wired)) begin
            rnd_d = RND_MAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            idx_q     <= '0;
            rnd_q     <= RND_MAX;
            rnd_cap_q <= '0;
            pidx_q    <= '0;
            pmiss_q   <= 1'b0;
            vpn2_q    <= '0;
            asid_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            if (accept) begin
                op_q      <= op_type;
                idx_q     <= cp0_index;
                rnd_cap_q <= rnd_q;
                vpn2_q    <= cp0_entryhi_vpn2;
                asid_q    <= cp0_entryhi_asid;
            end
            if (in_probe && !flush) begin
                pmiss_q <= !s1_found;
                pidx_q  <= s1_found ? s1_index : '0;
            end
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign s1_sel    = in_probe;
    assign exe_stall = in_probe && exe_lookup_req;
    assign s1_vpn2   = in_probe ? vpn2_q : '0;
    assign s1_asid   = in_probe ? asid_q : '0;

    // r_index stays on the latched Index through DONE so the CP0
    // load sees stable read data.
    assign r_index = ((state_q == S_READ) || (in_done && op_q == OP_TLBR))
                     ? idx_q : '0;

    assign we      = (state_q == S_WRITE);
    assign w_index = !we ? '0 : ((op_q == OP_TLBWR) ? rnd_cap_q : idx_q);

    assign cp0_random   = rnd_q;
    assign op_done      = in_done;
    assign cp0_index_we = in_done && (op_q == OP_TLBP);
    assign cp0_tlbr_we  = in_done && (op_q == OP_TLBR);
    assign refetch      = in_done && op_q[1];
    assign probe_miss   = pmiss_q;
    assign probe_index  = pidx_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: self-checking bench for tlb_op_ctrl with a small
// TLB array model, a Random-register model and table/random ops.
module tb_tlb_op_ctrl;

    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;
    localparam logic [1:0] P  = 2'b00;
    localparam logic [1:0] R  = 2'b01;
    localparam logic [1:0] WI = 2'b10;
    localparam logic [1:0] WR = 2'b11;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             op_valid;
    logic [1:0]       op_type;
    logic             op_ready;
    logic             flush;
    logic [18:0]      cp0_entryhi_vpn2;
    logic [7:0]       cp0_entryhi_asid;
    logic [IDX_W-1:0] cp0_index;
    logic [IDX_W-1:0] cp0_wired;
    logic             cp0_wired_we;
    logic             exe_lookup_req;
    logic             exe_stall;
    logic             s1_sel;
    logic [18:0]      s1_vpn2;
    logic [7:0]       s1_asid;
    logic             s1_found;
    logic [IDX_W-1:0] s1_index;
    logic [IDX_W-1:0] r_index;
    logic             we;
    logic [IDX_W-1:0] w_index;
    logic [IDX_W-1:0] cp0_random;
    logic             op_done;
    logic             cp0_index_we;
    logic             probe_miss;
    logic [IDX_W-1:0] probe_index;
    logic             cp0_tlbr_we;
    logic             refetch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
        .flush(flush),
        .cp0_entryhi_vpn2(cp0_entryhi_vpn2),
        .cp0_entryhi_asid(cp0_entryhi_asid),
        .cp0_index(cp0_index), .cp0_wired(cp0_wired),
        .cp0_wired_we(cp0_wired_we),
        .exe_lookup_req(exe_lookup_req), .exe_stall(exe_stall),
        .s1_sel(s1_sel), .s1_vpn2(s1_vpn2), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index),
        .r_index(r_index), .we(we), .w_index(w_index),
        .cp0_random(cp0_random), .op_done(op_done),
        .cp0_index_we(cp0_index_we), .probe_miss(probe_miss),
        .probe_index(probe_index), .cp0_tlbr_we(cp0_tlbr_we),
        .refetch(refetch)
    );

    // TLB array model: preload port plus the DUT write port
    logic [18:0]      tlb_vpn  [TLBNUM];
    logic [7:0]       tlb_asid [TLBNUM];
    logic             tlb_v    [TLBNUM];
    logic             tb_clr;
    logic             pl_we;
    logic [IDX_W-1:0] pl_idx;
    logic [18:0]      exe_vpn;
    logic [7:0]       exe_asid;
    logic [18:0]      sv;
    logic [7:0]       sa;

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < TLBNUM; i++) tlb_v[i] <= 1'b0;
        end else if (pl_we || we) begin
            tlb_vpn[pl_we ? pl_idx : w_index]  <= cp0_entryhi_vpn2;
            tlb_asid[pl_we ? pl_idx : w_index] <= cp0_entryhi_asid;
            tlb_v[pl_we ? pl_idx : w_index]    <= 1'b1;
        end
    end

    always_comb begin
        sv = s1_sel ? s1_vpn2 : exe_vpn;
        sa = s1_sel ? s1_asid : exe_asid;
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (tlb_v[i] && tlb_vpn[i] == sv && tlb_asid[i] == sa) begin
                s1_found = 1'b1;
                s1_index = IDX_W'(i);
            end
        end
    end

    // Random register reference: counts down, reloads to the top
    // whenever Wired is written or the floor is reached.
    int mdl_rnd = TLBNUM - 1;
    always @(posedge clk or posedge reset) begin
        if (reset) mdl_rnd <= TLBNUM - 1;
        else if (cp0_wired_we || mdl_rnd <= int'(cp0_wired))
            mdl_rnd <= TLBNUM - 1;
        else mdl_rnd <= mdl_rnd - 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) chk("random_model", cp0_random, mdl_rnd);

    function automatic logic [4:0] ref_probe(input logic [18:0] v,
                                             input logic [7:0] a);
        for (int i = 0; i < TLBNUM; i++)
            if (tlb_v[i] && tlb_vpn[i] == v && tlb_asid[i] == a)
                return {1'b0, IDX_W'(i)};
        return 5'b10000;
    endfunction

    task automatic load(input logic [3:0] i, input logic [18:0] v,
                        input logic [7:0] a);
        cp0_entryhi_vpn2 = v;
        cp0_entryhi_asid = a;
        pl_idx = i;
        pl_we = 1'b1;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic set_wired(input logic [3:0] w);
        cp0_wired = w;
        cp0_wired_we = 1'b1;
        @(posedge clk); #1;
        cp0_wired_we = 1'b0;
        @(negedge clk);
        chk("wired_we_rnd", cp0_random, TLBNUM - 1);
        @(posedge clk); #1;
    endtask

    // fl: 0 no flush, 1 flush in work cycle, 2 flush in DONE cycle
    task automatic run_op(input logic [1:0] op, input logic [3:0] idx,
                          input int fl, input logic xr,
                          input logic emiss, input logic [3:0] epidx);
        int  rnd_at;
        bit  abrt;
        abrt = (fl == 1) && !op[1];
        op_valid = 1'b1;
        op_type = op;
        cp0_index = idx;
        flush = 1'b0;
        exe_lookup_req = xr;
        @(negedge clk);
        chk("T_ready", op_ready, 1);
        chk("T_stall", exe_stall, 0);
        rnd_at = cp0_random;
        @(posedge clk); #1;
        op_valid = 1'b0;
        cp0_index = ~idx;
        flush = (fl == 1);
        @(negedge clk);
        chk("W_ready", op_ready, 0);
        chk("W_sel", s1_sel, op == P);
        chk("W_stall", exe_stall, (op == P) && xr);
        chk("W_we", we, op[1]);
        if (op == P) chk("W_vpn2", s1_vpn2, cp0_entryhi_vpn2);
        if (op == R) chk("W_rindex", r_index, idx);
        if (op == WI) chk("W_windex", w_index, idx);
        if (op == WR) begin
            chk("W_windex_rnd", w_index, rnd_at);
            chk("W_wr_range", w_index >= cp0_wired, 1);
        end
        @(posedge clk); #1;
        flush = (fl == 2);
        @(negedge clk);
        chk("D_done", op_done, !abrt);
        chk("D_ready", op_ready, abrt);
        chk("D_idx_we", cp0_index_we, !abrt && op == P);
        chk("D_tlbr_we", cp0_tlbr_we, !abrt && op == R);
        chk("D_refetch", refetch, !abrt && op[1]);
        chk("D_stall", exe_stall, 0);
        chk("D_sel", s1_sel, 0);
        chk("D_we", we, 0);
        if (!abrt && op == P) begin
            chk("D_miss", probe_miss, emiss);
            chk("D_pidx", probe_index, epidx);
        end
        if (!abrt && op == R) chk("D_rindex", r_index, idx);
        @(posedge clk); #1;
        flush = 1'b0;
        exe_lookup_req = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  idx;
        logic [18:0] vpn;
        logic [7:0]  asid;
        int          fl;
        logic        xr;
        logic        miss;
        logic [3:0]  pidx;
    } vec_t;

    vec_t vt[10];

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [4:0] pr;
        logic [1:0] op;
        int fl;
        op_valid = 0; op_type = 0; flush = 0;
        cp0_entryhi_vpn2 = 0; cp0_entryhi_asid = 0;
        cp0_index = 0; cp0_wired = 0; cp0_wired_we = 0;
        exe_lookup_req = 0; exe_vpn = 19'h7ffff; exe_asid = 8'hff;
        tb_clr = 1; pl_we = 0; pl_idx = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ready", op_ready, 1);
        chk("rst_random", cp0_random, 15);
        chk("rst_strobes",
            {s1_sel, exe_stall, we, op_done, cp0_index_we,
             cp0_tlbr_we, refetch, probe_miss}, 0);
        chk("rst_regs", {probe_index, w_index, r_index}, 0);
        chk("rst_s1", {s1_vpn2, s1_asid}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tb_clr = 1'b0;

        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk("rnd_seq", cp0_random, 15 - (k % 16));
            chk("idle_ready", op_ready, 1);
        end
        @(posedge clk); #1;

        load(4'd9, 19'h12345, 8'h07);
        load(4'd2, 19'h00abc, 8'h11);

        vt[0] = '{P,  4'd0, 19'h12345, 8'h07, 0, 1'b0, 1'b0, 4'd9};
        vt[1] = '{P,  4'd0, 19'h54321, 8'h07, 0, 1'b0, 1'b1, 4'd0};
        vt[2] = '{P,  4'd0, 19'h00abc, 8'h11, 0, 1'b1, 1'b0, 4'd2};
        vt[3] = '{WI, 4'd3, 19'h0beef, 8'h22, 0, 1'b0, 1'b0, 4'd0};
        vt[4] = '{R,  4'd3, 19'h0beef, 8'h22, 0, 1'b0, 1'b0, 4'd0};
        vt[5] = '{P,  4'd0, 19'h0beef, 8'h22, 0, 1'b1, 1'b0, 4'd3};
        vt[6] = '{P,  4'd0, 19'h12345, 8'h07, 1, 1'b1, 1'b0, 4'd0};
        vt[7] = '{WI, 4'd5, 19'h11111, 8'h33, 1, 1'b0, 1'b0, 4'd0};
        vt[8] = '{P,  4'd0, 19'h11111, 8'h33, 0, 1'b0, 1'b0, 4'd5};
        vt[9] = '{R,  4'd7, 19'h11111, 8'h33, 2, 1'b0, 1'b0, 4'd0};

        for (int i = 0; i < 10; i++) begin
            cp0_entryhi_vpn2 = vt[i].vpn;
            cp0_entryhi_asid = vt[i].asid;
            run_op(vt[i].op, vt[i].idx, vt[i].fl, vt[i].xr,
                   vt[i].miss, vt[i].pidx);
        end

        // flush while idle blocks acceptance
        op_valid = 1'b1; op_type = WI; cp0_index = 4'd1; flush = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_ready", op_ready, 1);
        chk("idle_flush_we", we, 0);
        @(posedge clk); #1;

        // reset in the write cycle suppresses the write at once
        op_valid = 1'b1; op_type = WI; cp0_index = 4'd6;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_we", we, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_ready", op_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        pr = ref_probe(cp0_entryhi_vpn2, cp0_entryhi_asid);
        run_op(P, 4'd0, 0, 1'b0, pr[4], pr[3:0]);

        // TLBWR with Wired = 12
        set_wired(4'd12);
        for (int i = 0; i < 50; i++) begin
            if (i == 25) set_wired(4'd12);
            cp0_entryhi_vpn2 = 19'h20000 + 19'(i);
            cp0_entryhi_asid = 8'h40;
            run_op(WR, 4'($urandom_range(0, 15)), 0, 1'b0, 1'b0, 4'd0);
        end

        // randomized mix against the model
        for (int i = 0; i < 60; i++) begin
            if (i % 8 == 0) set_wired(4'($urandom_range(0, 15)));
            op = 2'($urandom_range(0, 3));
            fl = $urandom_range(0, 5);
            if (fl > 2) fl = 0;
            cp0_entryhi_vpn2 = 19'($urandom_range(0, 7));
            cp0_entryhi_asid = 8'($urandom_range(0, 1));
            pr = ref_probe(cp0_entryhi_vpn2, cp0_entryhi_asid);
            run_op(op, 4'($urandom_range(0, 15)), fl,
                   1'($urandom_range(0, 1)), pr[4], pr[3:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
